// File: rtl/vga_frame_capture.sv
// Recovers VGA timing from sampled HS/VS/RGB, emits active-pixel coordinates and copies one window of a frame to a capture RAM port.
// Pixel outputs appear one clk after the pix_en sample; no backpressure, so the RAM port must accept every cap_we.
module vga_frame_capture #(
    parameter int WIDTH    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int WIN_X    = 200,
    parameter int WIN_Y    = 150,
    parameter int WIN_W    = 160,
    parameter int WIN_H    = 240,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              HS,
    input  logic              VS,
    input  logic [11:0]       vgaRGB,
    input  logic              cap_start,
    output logic              locked,
    output logic              frame_start,
    output logic              pix_valid,
    output logic [WIDTH-1:0]  x,
    output logic [WIDTH-1:0]  y,
    output logic [11:0]       rgb,
    output logic              cap_we,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [11:0]       cap_data,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              cap_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [WIDTH-1:0] H_LAST      = WIDTH'(H_TOTAL - 1);
    localparam logic [WIDTH-1:0] H_SYNC_LAST = WIDTH'(H_SYNC - 1);
    localparam logic [WIDTH-1:0] H_ACT_BEG   = WIDTH'(H_SYNC + H_BP);
    localparam logic [WIDTH-1:0] H_ACT_END   = WIDTH'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [WIDTH-1:0] V_LAST      = WIDTH'(V_TOTAL - 1);
    localparam logic [WIDTH-1:0] V_SYNC_LAST = WIDTH'(V_SYNC - 1);
    localparam logic [WIDTH-1:0] V_ACT_BEG   = WIDTH'(V_SYNC + V_BP);
    localparam logic [WIDTH-1:0] V_ACT_END   = WIDTH'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [WIDTH-1:0] WX_BEG      = WIDTH'(WIN_X);
    localparam logic [WIDTH-1:0] WX_LAST     = WIDTH'(WIN_X + WIN_W - 1);
    localparam logic [WIDTH-1:0] WY_BEG      = WIDTH'(WIN_Y);
    localparam logic [WIDTH-1:0] WY_LAST     = WIDTH'(WIN_Y + WIN_H - 1);

    typedef enum logic [1:0] {T_SEARCH, T_CHECK, T_LOCKED} tstate_t;
    typedef enum logic [1:0] {C_IDLE, C_ARMED, C_ACTIVE} cstate_t;

    logic              hs_s_q, vs_s_q;
    logic [11:0]       rgb_s_q;
    logic              hs_prev_q, vs_line_q;
    logic [WIDTH-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    tstate_t           tstate_q, tstate_d;
    logic              good_q, good_d;
    logic              hs_fall, hs_rise, vs_fall, vs_rise, chk_err;

    logic              h_act, v_act, in_win, win_last;
    logic [WIDTH-1:0]  px_x, px_y;
    logic              pix_valid_d, frame_start_d;
    logic              pix_valid_q, frame_start_q;
    logic [WIDTH-1:0]  x_q, y_q;
    logic [11:0]       rgb_q;

    cstate_t           cstate_q, cstate_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d, cap_addr_q;
    logic [11:0]       cap_data_q;
    logic              cap_we_d, cap_we_q, cap_last_q;
    logic              cap_done_d, cap_done_q, cap_err_d, cap_err_q;

    // Sync inputs idle high, so the sample history resets to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s_q  <= 1'b1;
            vs_s_q  <= 1'b1;
            rgb_s_q <= '0;
        end else begin
            hs_s_q  <= HS;
            vs_s_q  <= VS;
            rgb_s_q <= vgaRGB;
        end
    end

    assign hs_fall = pix_en && hs_prev_q && !hs_s_q;
    assign hs_rise = pix_en && !hs_prev_q && hs_s_q;
    assign vs_fall = hs_fall && vs_line_q && !vs_s_q;
    assign vs_rise = hs_fall && !vs_line_q && vs_s_q;

    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        tstate_d = tstate_q;
        good_d   = good_q;
        if (pix_en) h_cnt_d = hs_fall ? '0 : h_cnt_q + WIDTH'(1);
        if (vs_fall)      v_cnt_d = '0;
        else if (hs_fall) v_cnt_d = v_cnt_q + WIDTH'(1);
        // Counts are checked against the value held before this sample updates them.
        chk_err = (hs_fall && h_cnt_q != H_LAST)
               || (pix_en && !hs_fall && h_cnt_q == H_LAST)
               || (hs_rise && h_cnt_q != H_SYNC_LAST)
               || (vs_fall && v_cnt_q != V_LAST)
               || (hs_fall && !vs_fall && v_cnt_q == V_LAST)
               || (vs_rise && v_cnt_q != V_SYNC_LAST);
        case (tstate_q)
            T_SEARCH: if (vs_fall) begin
                tstate_d = T_CHECK;
                good_d   = 1'b0;
            end
            T_CHECK: begin
                if (chk_err) tstate_d = T_SEARCH;
                else if (vs_fall) begin
                    if (good_q) tstate_d = T_LOCKED;
                    else        good_d   = 1'b1;
                end
            end
            T_LOCKED: if (chk_err) tstate_d = T_SEARCH;
            default:  tstate_d = T_SEARCH;
        endcase
    end

    always_comb begin
        h_act         = (h_cnt_d >= H_ACT_BEG) && (h_cnt_d < H_ACT_END);
        v_act         = (v_cnt_d >= V_ACT_BEG) && (v_cnt_d < V_ACT_END);
        px_x          = h_cnt_d - H_ACT_BEG;
        px_y          = v_cnt_d - V_ACT_BEG;
        pix_valid_d   = pix_en && h_act && v_act && (tstate_d == T_LOCKED);
        frame_start_d = pix_valid_d && (px_x == '0) && (px_y == '0);
        in_win        = (px_x >= WX_BEG) && (px_x <= WX_LAST) && (px_y >= WY_BEG) && (px_y <= WY_LAST);
        win_last      = (px_x == WX_LAST) && (px_y == WY_LAST);
    end

    always_comb begin
        cstate_d   = cstate_q;
        wr_cnt_d   = wr_cnt_q;
        cap_we_d   = 1'b0;
        cap_done_d = 1'b0;
        cap_err_d  = 1'b0;
        case (cstate_q)
            C_IDLE: if (cap_start && locked && !cap_done_q) begin
                cstate_d = C_ARMED;
                wr_cnt_d = '0;
            end
            C_ARMED: begin
                if (!locked) begin
                    cstate_d  = C_IDLE;
                    cap_err_d = 1'b1;
                end else if (frame_start_d) begin
                    cstate_d = C_ACTIVE;
                    cap_we_d = pix_valid_d && in_win;
                end
            end
            C_ACTIVE: begin
                if (cap_we_q && cap_last_q) begin
                    cstate_d   = C_IDLE;
                    cap_done_d = 1'b1;
                end else if (!locked) begin
                    cstate_d  = C_IDLE;
                    cap_err_d = 1'b1;
                end else begin
                    cap_we_d = pix_valid_d && in_win;
                end
            end
            default: cstate_d = C_IDLE;
        endcase
        if (cap_we_d) wr_cnt_d = wr_cnt_q + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev_q     <= 1'b1;
            vs_line_q     <= 1'b1;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            tstate_q      <= T_SEARCH;
            good_q        <= 1'b0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            cstate_q      <= C_IDLE;
            wr_cnt_q      <= '0;
            cap_we_q      <= 1'b0;
            cap_last_q    <= 1'b0;
            cap_addr_q    <= '0;
            cap_data_q    <= '0;
            cap_done_q    <= 1'b0;
            cap_err_q     <= 1'b0;
        end else begin
            if (pix_en)  hs_prev_q <= hs_s_q;
            if (hs_fall) vs_line_q <= vs_s_q;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            tstate_q      <= tstate_d;
            good_q        <= good_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            if (pix_valid_d) begin
                x_q   <= px_x;
                y_q   <= px_y;
                rgb_q <= rgb_s_q;
            end
            cstate_q   <= cstate_d;
            wr_cnt_q   <= wr_cnt_d;
            cap_we_q   <= cap_we_d;
            cap_done_q <= cap_done_d;
            cap_err_q  <= cap_err_d;
            if (cap_we_d) begin
                cap_addr_q <= wr_cnt_q;
                cap_data_q <= rgb_s_q;
                cap_last_q <= win_last;
            end
        end
    end

    assign locked      = (tstate_q == T_LOCKED);
    assign frame_start = frame_start_q;
    assign pix_valid   = pix_valid_q;
    assign x           = x_q;
    assign y           = y_q;
    assign rgb         = rgb_q;
    assign cap_we      = cap_we_q;
    assign cap_addr    = cap_addr_q;
    assign cap_data    = cap_data_q;
    assign cap_busy    = (cstate_q != C_IDLE);
    assign cap_done    = cap_done_q;
    assign cap_err     = cap_err_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a shrunken 15x11 raster with a 4x3 capture window.
module tb_vga_frame_capture;

    localparam int WIDTH = 10, ADDR_W = 16;
    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 2;
    localparam int WIN_X = 2, WIN_Y = 1, WIN_W = 4, WIN_H = 3;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int N_WIN   = WIN_W * WIN_H;

    logic clk, rst_n, pix_en, HS, VS, cap_start;
    logic [11:0] vgaRGB;
    logic locked, frame_start, pix_valid, cap_we, cap_busy, cap_done, cap_err;
    logic [WIDTH-1:0] x, y;
    logic [11:0] rgb, cap_data;
    logic [ADDR_W-1:0] cap_addr;

    vga_frame_capture #(
        .WIDTH(WIDTH), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W(WIN_W), .WIN_H(WIN_H), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .HS(HS), .VS(VS), .vgaRGB(vgaRGB),
        .cap_start(cap_start), .locked(locked), .frame_start(frame_start), .pix_valid(pix_valid),
        .x(x), .y(y), .rgb(rgb), .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
        .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errs = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int n_valid, n_fs, n_bad_fs, n_we, n_bad_we, n_done, n_err;
    int last_we_cyc, done_cyc, err_cyc;
    logic [11:0] rgb_org, rgb_end;
    logic [ADDR_W-1:0] wq_addr[$];
    logic [11:0] wq_data[$];

    always @(negedge clk) begin
        if (pix_valid) begin
            n_valid++;
            if (int'(x) == 0 && int'(y) == 0) rgb_org = rgb;
            if (int'(x) == H_ACTIVE - 1 && int'(y) == V_ACTIVE - 1) rgb_end = rgb;
        end
        if (frame_start) begin
            n_fs++;
            if (!(pix_valid && int'(x) == 0 && int'(y) == 0)) n_bad_fs++;
        end
        if (cap_we) begin
            n_we++;
            last_we_cyc = cyc;
            wq_addr.push_back(cap_addr);
            wq_data.push_back(cap_data);
            if (!pix_valid) n_bad_we++;
        end
        if (cap_done) begin n_done++; done_cyc = cyc; end
        if (cap_err)  begin n_err++;  err_cyc  = cyc; end
    end

    task automatic clear_mon();
        n_valid = 0; n_fs = 0; n_bad_fs = 0; n_we = 0; n_bad_we = 0; n_done = 0; n_err = 0;
        last_we_cyc = -1; done_cyc = -1; err_cyc = -1;
        rgb_org = 12'hXXX; rgb_end = 12'hXXX;
        wq_addr.delete(); wq_data.delete();
    endtask

    function automatic logic [11:0] pat(input int px, input int py);
        logic [31:0] vx, vy;
        vx = px; vy = py;
        return {vx[3:0], vy[3:0], 4'hA};
    endfunction

    // Data is presented one clk ahead of the pix_en strobe to cover the input register stage.
    task automatic drive_pixel(input logic hs, input logic vs, input logic [11:0] c, input logic cs);
        @(posedge clk); #1;
        HS = hs; VS = vs; vgaRGB = c; cap_start = cs;
        @(posedge clk); #1;
        pix_en = 1'b1; cap_start = 1'b0;
        @(posedge clk); #1;
        pix_en = 1'b0;
        @(posedge clk);
    endtask

    task automatic send_frame(input int short_line, input int cs_line, input int stop_line);
        for (int v = 0; v < V_TOTAL; v++) begin
            if (v == stop_line) return;
            for (int h = 0; h < H_TOTAL; h++) begin
                int hs_len;
                logic act;
                hs_len = (v == short_line) ? H_SYNC - 1 : H_SYNC;
                act = (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACTIVE) &&
                      (v >= V_SYNC + V_BP) && (v < V_SYNC + V_BP + V_ACTIVE);
                drive_pixel(h >= hs_len, v >= V_SYNC,
                            act ? pat(h - H_SYNC - H_BP, v - V_SYNC - V_BP) : 12'h000,
                            (v == cs_line) && (h == 0));
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; cap_start = 1'b1;
        @(posedge clk); #1; cap_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, 32'({locked, frame_start, pix_valid, cap_we, cap_busy, cap_done, cap_err}), 32'd0);
        check_eq({tag, "_xy"}, 32'({x, y}), 32'd0);
        check_eq({tag, "_rgb"}, 32'(rgb), 32'd0);
        check_eq({tag, "_cap_addr"}, 32'(cap_addr), 32'd0);
        check_eq({tag, "_cap_data"}, 32'(cap_data), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; HS = 1'b1; VS = 1'b1; vgaRGB = 12'h000; cap_start = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) drive_pixel(1'b1, 1'b1, 12'h000, 1'b0);

        pulse_start();
        check_eq("unlocked_start_busy", 32'(cap_busy), 32'd0);

        send_frame(-1, -1, -1);
        check_eq("f1_locked", 32'(locked), 32'd0);
        check_eq("f1_valid_cnt", n_valid, 0);
        send_frame(-1, -1, -1);
        check_eq("f2_locked", 32'(locked), 32'd0);
        check_eq("unlocked_start_writes", n_we, 0);

        clear_mon();
        send_frame(-1, -1, -1);
        check_eq("f3_locked", 32'(locked), 32'd1);
        check_eq("f3_valid_cnt", n_valid, H_ACTIVE * V_ACTIVE);
        check_eq("f3_fs_cnt", n_fs, 1);
        check_eq("f3_fs_at_origin", n_bad_fs, 0);
        check_eq("rgb_origin", 32'(rgb_org), 32'h00A);
        check_eq("rgb_last", 32'(rgb_end), 32'h75A);

        clear_mon();
        pulse_start();
        check_eq("armed_busy", 32'(cap_busy), 32'd1);
        send_frame(-1, 6, -1);
        check_eq("cap_we_cnt", n_we, N_WIN);
        for (int i = 0; i < N_WIN; i++) begin
            check_eq("cap_addr_seq", (i < wq_addr.size()) ? 32'(wq_addr[i]) : 32'hFFFF_FFFF, i);
            check_eq("cap_data_seq", (i < wq_data.size()) ? 32'(wq_data[i]) : 32'hFFFF_FFFF,
                     32'(pat(WIN_X + i % WIN_W, WIN_Y + i / WIN_W)));
        end
        check_eq("cap_we_with_valid", n_bad_we, 0);
        check_eq("cap_done_cnt", n_done, 1);
        check_eq("cap_done_delay", done_cyc - last_we_cyc, 1);
        check_eq("cap_err_clean", n_err, 0);
        check_eq("cap_busy_after", 32'(cap_busy), 32'd0);
        check_eq("f4_valid_cnt", n_valid, H_ACTIVE * V_ACTIVE);

        clear_mon();
        send_frame(-1, -1, -1);
        check_eq("second_start_writes", n_we, 0);
        check_eq("f5_locked", 32'(locked), 32'd1);

        clear_mon();
        pulse_start();
        send_frame(6, -1, -1);
        check_eq("lossy_we_cnt", n_we, WIN_W);
        check_eq("lossy_err_cnt", n_err, 1);
        check_eq("lossy_no_wr_after_err", 32'(err_cyc > last_we_cyc), 32'd1);
        check_eq("lossy_done_cnt", n_done, 0);
        check_eq("lossy_locked", 32'(locked), 32'd0);
        check_eq("lossy_busy", 32'(cap_busy), 32'd0);
        check_eq("lossy_valid_cnt", n_valid, 2 * H_ACTIVE);
        send_frame(-1, -1, -1);
        check_eq("relock_f1", 32'(locked), 32'd0);
        send_frame(-1, -1, -1);
        check_eq("relock_f2", 32'(locked), 32'd0);
        clear_mon();
        send_frame(-1, -1, -1);
        check_eq("relock_f3", 32'(locked), 32'd1);
        check_eq("relock_valid_cnt", n_valid, H_ACTIVE * V_ACTIVE);

        clear_mon();
        pulse_start();
        send_frame(-1, -1, 6);
        check_eq("pre_rst_we_cnt", n_we, WIN_W);
        check_eq("pre_rst_busy", 32'(cap_busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midcap_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon();
        send_frame(-1, -1, -1);
        check_eq("post_rst_we", n_we, 0);
        check_eq("post_rst_done", n_done, 0);
        check_eq("post_rst_err", n_err, 0);
        check_eq("post_rst_locked", 32'(locked), 32'd0);
        check_eq("post_rst_busy", 32'(cap_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
